// File: rtl/mul_dispatch_pkg.sv
// rtl/mul_dispatch_pkg.sv - shared op codes and default widths for the mul/div dispatch slice
package mul_dispatch_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RW_DEF    = 5;
  localparam int DEPTH_DEF = 2;

  // RISC-V M-extension funct3 encodings carried on exe_para/mul_para
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } funct3_e;

endpackage

// File: rtl/mul_tag_fifo.sv
// rtl/mul_tag_fifo.sv - in-order FIFO of destination registers for ops outstanding in mul
module mul_tag_fifo
  import mul_dispatch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [RW-1:0]     push_rd,
  input  logic              pop,
  output logic [RW-1:0]     pop_rd,
  output logic              full,
  output logic              empty,
  output logic [2**RW-1:0]  busy_map
);

  // DEPTH is a power of two, so PW-bit pointers wrap on their own
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_rd  = mem[rd_ptr];

  // Pointer/count bookkeeping; a flush drops every outstanding tag at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_rd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Decode every live entry (distance from rd_ptr below count) into a register bitmap
  always_comb begin
    busy_map = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count) busy_map[mem[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - issue side of the mul/div protocol: request register, tag tracking, writeback
module mul_dispatch
  import mul_dispatch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_pipeline,
  input  logic              exe_vld,
  input  logic [2:0]        exe_para,
  input  logic [XLEN-1:0]   exe_rs0,
  input  logic [XLEN-1:0]   exe_rs1,
  input  logic [RW-1:0]     exe_rd,
  output logic              exe_rdy,
  output logic              mul_initial,
  output logic [2:0]        mul_para,
  output logic [XLEN-1:0]   mul_rs0,
  output logic [XLEN-1:0]   mul_rs1,
  input  logic              mul_ready,
  input  logic              mul_finished,
  input  logic [XLEN-1:0]   mul_data,
  output logic              mul_ack,
  output logic              wb_vld,
  output logic [RW-1:0]     wb_rd,
  output logic [XLEN-1:0]   wb_data,
  input  logic              wb_rdy,
  output logic [2**RW-1:0]  busy_rd
);

  logic             req_vld;
  logic [RW-1:0]    req_rd;
  logic             issue;
  logic             accept;
  logic             tagq_full;
  logic             tagq_empty;
  logic [RW-1:0]    tag_rd;
  logic [2**RW-1:0] tag_busy;
  logic             tag_pop;
  logic             wb_load;

  // An op can leave the request register only if a tag slot is free to remember its rd
  assign issue       = req_vld & mul_ready & ~tagq_full & ~clear_pipeline;
  assign mul_initial = issue;
  assign exe_rdy     = (~req_vld | issue) & ~clear_pipeline & ~rst;
  assign accept      = exe_vld & exe_rdy;

  // Orphan results (no tag left after a flush) are always swallowed so mul never stalls
  assign mul_ack = mul_finished & ~clear_pipeline & (tagq_empty | ~wb_vld | wb_rdy);
  assign tag_pop = mul_ack & ~tagq_empty;
  assign wb_load = tag_pop & (tag_rd != '0);

  // Request register: operands stay frozen on mul_* until the op is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_vld  <= 1'b0;
      req_rd   <= '0;
      mul_para <= '0;
      mul_rs0  <= '0;
      mul_rs1  <= '0;
    end else if (clear_pipeline) begin
      req_vld <= 1'b0;
    end else if (accept) begin
      req_vld  <= 1'b1;
      req_rd   <= exe_rd;
      mul_para <= exe_para;
      mul_rs0  <= exe_rs0;
      mul_rs1  <= exe_rs1;
    end else if (issue) begin
      req_vld <= 1'b0;
    end
  end

  mul_tag_fifo #(
    .DEPTH (DEPTH),
    .RW    (RW)
  ) u_tagq (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear_pipeline),
    .push     (issue),
    .push_rd  (req_rd),
    .pop      (tag_pop),
    .pop_rd   (tag_rd),
    .full     (tagq_full),
    .empty    (tagq_empty),
    .busy_map (tag_busy)
  );

  // Writeback register: survives a flush because its instruction is already committed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (wb_load) begin
      wb_vld  <= 1'b1;
      wb_rd   <= tag_rd;
      wb_data <= mul_data;
    end else if (wb_vld && wb_rdy) begin
      wb_vld <= 1'b0;
    end
  end

  // Hazard bitmap: pending request, in-flight tags and unretired writeback; x0 never busy
  always_comb begin
    busy_rd = tag_busy;
    if (req_vld) busy_rd[req_rd] = 1'b1;
    if (wb_vld)  busy_rd[wb_rd]  = 1'b1;
    busy_rd[0] = 1'b0;
  end

endmodule
